// File: rtl/mode_select_ctrl_pkg.sv
// mode_select_ctrl_pkg: mode codes shared with the pattern generator and default timing values
package mode_select_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_SHIFT   = 2'b00,
        MODE_COUNT   = 2'b01,
        MODE_JOHNSON = 2'b10
    } mode_e;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int TICK_DIV_DEF        = 12500000;
endpackage

// File: rtl/mode_select_ctrl_if.sv
// mode_select_ctrl_if: raw buttons in, mode/pattern_rst/step/running out
// master = button/generator side, slave = mode_select_ctrl
interface mode_select_ctrl_if;
    import mode_select_ctrl_pkg::*;
    logic  btn_next;
    logic  btn_pause;
    mode_e mode;
    logic  pattern_rst;
    logic  step;
    logic  running;
    modport master (output btn_next, btn_pause, input mode, pattern_rst, step, running);
    modport slave (input btn_next, btn_pause, output mode, pattern_rst, step, running);
endinterface

// File: rtl/mode_select_ctrl_btn_debounce.sv
// btn_debounce: two-flop sync, stable-count debounce, one-cycle press pulse on debounced rise
// ports: clk, reset (async high), btn_i raw button, press_o registered press pulse
module btn_debounce import mode_select_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    logic s1_q, s2_q, db_q, db_dly_q, press_q;
    logic db_d, hit;
    logic [CW-1:0] cnt_q, cnt_d;
    // level accepted once it has differed from db for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        hit   = (s2_q != db_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d = (s2_q == db_q || hit) ? '0 : cnt_q + 1'b1;
        db_d  = hit ? s2_q : db_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {s1_q, s2_q, db_q, db_dly_q, press_q} <= '0;
            cnt_q <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/mode_select_ctrl.sv
// mode_select_ctrl: debounced buttons drive mode FSM, run/pause flag and step prescaler
// ports: clk, reset (async high), bus (slave: btn_next/btn_pause in; mode/pattern_rst/step/running out)
module mode_select_ctrl import mode_select_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input logic               clk,
    input logic               reset,
    mode_select_ctrl_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    logic press_next, press_pause;
    mode_e mode_q, mode_d;
    logic running_q, pattern_rst_q, step_q, tc;
    logic [TW-1:0] tick_q, tick_d;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .reset(reset), .btn_i(bus.btn_next), .press_o(press_next)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .reset(reset), .btn_i(bus.btn_pause), .press_o(press_pause)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mode_q <= MODE_SHIFT;
        else mode_q <= mode_d;
    end
    // any unexpected code falls back to MODE_SHIFT on the next press
    always_comb begin
        mode_d = !press_next ? mode_q :
                 mode_q == MODE_SHIFT ? MODE_COUNT :
                 mode_q == MODE_COUNT ? MODE_JOHNSON : MODE_SHIFT;
    end
    // a mode change clears the prescaler and wins over a coincident terminal count
    always_comb begin
        tc     = tick_q == TW'(TICK_DIV - 1);
        tick_d = (press_next || (running_q && tc)) ? '0 : running_q ? tick_q + 1'b1 : tick_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_q     <= 1'b1;
            pattern_rst_q <= 1'b0;
            step_q        <= 1'b0;
            tick_q        <= '0;
        end else begin
            running_q     <= running_q ^ press_pause;
            pattern_rst_q <= press_next;
            step_q        <= running_q && tc && !press_next;
            tick_q        <= tick_d;
        end
    end
    always_comb begin
        bus.mode        = mode_q;
        bus.pattern_rst = pattern_rst_q;
        bus.step        = step_q;
        bus.running     = running_q;
    end
endmodule

// File: tb/tb_mode_select_ctrl.sv
// tb_mode_select_ctrl: directed scenarios checked against a windowed behavioural model every cycle
module tb_mode_select_ctrl;
    import mode_select_ctrl_pkg::*;
    localparam int D = 4;
    localparam int T = 5;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks   = 0;
    int failures = 0;
    mode_select_ctrl_if bus();
    mode_select_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a button level is accepted when the last D synchronised samples all differ
    // from the current level; a rise takes effect on mode/running two edges later.
    // step fires when the count of running edges since the last clear is a multiple of T.
    bit hn[D+2];
    bit hp[D+2];
    bit dbn = 0, dbp = 0;
    bit [1:0] dn = 0, dp = 0;
    bit adv, tog, fn, fp;
    int m = 0, k = 0;
    bit e_run = 1, e_rst = 0, e_step = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D + 2; i++) begin hn[i] = 0; hp[i] = 0; end
            dbn = 0; dbp = 0; dn = 0; dp = 0;
            m = 0; k = 0; e_run = 1; e_rst = 0; e_step = 0;
        end else begin
            adv = dn[1];
            tog = dp[1];
            for (int i = D + 1; i > 0; i--) begin hn[i] = hn[i-1]; hp[i] = hp[i-1]; end
            hn[0] = bus.btn_next;
            hp[0] = bus.btn_pause;
            fn = 1; fp = 1;
            for (int i = 2; i <= D + 1; i++) begin
                if (hn[i] == dbn) fn = 0;
                if (hp[i] == dbp) fp = 0;
            end
            dn = {dn[0], fn & ~dbn};
            dp = {dp[0], fp & ~dbp};
            if (fn) dbn = ~dbn;
            if (fp) dbp = ~dbp;
            e_rst = adv;
            if (adv) begin m = (m + 1) % 3; k = 0; e_step = 0; end
            else if (e_run) begin k++; e_step = (k % T == 0); end
            else e_step = 0;
            if (tog) e_run = !e_run;
        end
    end

    always @(negedge clk) begin
        check("mdl_mode", int'(bus.mode), m);
        check("mdl_pattern_rst", int'(bus.pattern_rst), int'(e_rst));
        check("mdl_step", int'(bus.step), int'(e_step));
        check("mdl_running", int'(bus.running), int'(e_run));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_step();
        int n = 0;
        while (bus.step !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("step_seen", int'(bus.step === 1'b1), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int em[3] = '{1, 2, 0};
    bit pat[8] = '{1, 0, 1, 1, 0, 1, 1, 1};
    int prev, nsteps, nrst;
    initial begin
        bus.btn_next  = 0;
        bus.btn_pause = 0;
        tick(2);
        #2 reset = 0;
        // 1: idle after reset
        nsteps = 0; nrst = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            nsteps += int'(bus.step);
            nrst   += int'(bus.pattern_rst);
        end
        check("t1_steps", nsteps, 4);
        check("t1_prst", nrst, 0);
        check("t1_mode", int'(bus.mode), 0);
        check("t1_running", int'(bus.running), 1);
        // 2: three next presses cycle the mode
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            bus.btn_next = 1;
            tick(7);
            check("t2_mode_before", int'(bus.mode), prev);
            tick(1);
            check("t2_mode", int'(bus.mode), em[i]);
            check("t2_prst", int'(bus.pattern_rst), 1);
            tick(1);
            check("t2_prst_after", int'(bus.pattern_rst), 0);
            tick(1);
            bus.btn_next = 0;
            tick(3);
            check("t2_step", int'(bus.step), 1);
            tick(12);
            prev = em[i];
        end
        // 3: bounce without a run of D
        nrst = 0;
        for (int i = 0; i < 8; i++) begin
            bus.btn_next = pat[i];
            tick(1);
            nrst += int'(bus.pattern_rst);
        end
        bus.btn_next = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            nrst += int'(bus.pattern_rst);
        end
        check("t3_prst", nrst, 0);
        check("t3_mode", int'(bus.mode), 0);
        // 4: pause with prescaler at 2, resume 30 cycles later
        tick(1);
        wait_step();
        bus.btn_pause = 1;
        tick(7);
        check("t4_run_before", int'(bus.running), 1);
        tick(1);
        check("t4_paused", int'(bus.running), 0);
        tick(2);
        bus.btn_pause = 0;
        nsteps = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            nsteps += int'(bus.step);
        end
        check("t4_paused_steps", nsteps, 0);
        bus.btn_pause = 1;
        tick(7);
        check("t4_still_paused", int'(bus.running), 0);
        tick(1);
        check("t4_resumed", int'(bus.running), 1);
        tick(1);
        check("t4_step_r1", int'(bus.step), 0);
        tick(1);
        check("t4_step_r2", int'(bus.step), 1);
        bus.btn_pause = 0;
        tick(12);
        // mode change on the prescaler's terminal-count edge suppresses step
        tick(1);
        wait_step();
        tick(2);
        bus.btn_next = 1;
        tick(8);
        check("tc_prst", int'(bus.pattern_rst), 1);
        check("tc_step", int'(bus.step), 0);
        check("tc_mode", int'(bus.mode), 1);
        tick(2);
        bus.btn_next = 0;
        tick(3);
        check("tc_step_next", int'(bus.step), 1);
        tick(12);
        // 5: simultaneous presses
        bus.btn_next  = 1;
        bus.btn_pause = 1;
        tick(7);
        check("t5_mode_before", int'(bus.mode), 1);
        check("t5_run_before", int'(bus.running), 1);
        tick(1);
        check("t5_mode", int'(bus.mode), 2);
        check("t5_running", int'(bus.running), 0);
        check("t5_prst", int'(bus.pattern_rst), 1);
        tick(2);
        bus.btn_next  = 0;
        bus.btn_pause = 0;
        tick(12);
        // 6: reset during a held press, keep holding afterwards
        bus.btn_next = 1;
        tick(2);
        #2 reset = 1;
        tick(1);
        check("t6_rst_mode", int'(bus.mode), 0);
        check("t6_rst_running", int'(bus.running), 1);
        check("t6_rst_step", int'(bus.step), 0);
        #2 reset = 0;
        tick(7);
        check("t6_mode_before", int'(bus.mode), 0);
        tick(1);
        check("t6_mode", int'(bus.mode), 1);
        check("t6_prst", int'(bus.pattern_rst), 1);
        tick(5);
        check("t6_hold_one_press", int'(bus.mode), 1);
        bus.btn_next = 0;
        tick(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mode_select_ctrl.md
# mode_select_ctrl

Front-end for the LED pattern generator. Reads raw board push-buttons and produces what the generator consumes: a clean 2-bit `mode` code, a one-cycle `pattern_rst` pulse on every mode change, and a prescaled `step` strobe that paces the pattern. Each button is synchronised and debounced. `btn_next` cycles the mode and `btn_pause` freezes stepping. Targets the Spartan-3E board clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- `TICK_DIV`, default 12500000: clock cycles per `step` strobe (4 Hz at 50 MHz). Must be ≥2.
- `clk` in 1: board clock. Single clock domain.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `btn_next` in 1: raw, asynchronous, active-high button that advances the mode.
- `btn_pause` in 1: raw, asynchronous, active-high button that toggles run/pause.
- `mode` out 2: current pattern code.
- `pattern_rst` out 1: one-cycle pulse; the generator reloads its initial pattern.
- `step` out 1: one-cycle advance strobe.
- `running` out 1: high when stepping is enabled.

## Operation
- **Reset values (all registered outputs):** `mode`=2'b00, `pattern_rst`=0, `step`=0, `running`=1. Synchroniser flops, debounced levels and all counters are 0.
- **Debounce, per button:**
  - Two-flop synchroniser stages `s1` and `s2`, then a stable counter against a debounced level `db`.
  - If `s2`≠`db`, the counter increments. If `s2`==`db`, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while `s2`≠`db`, `db` takes `s2` and the counter clears.
  - Any bounce shorter than `DEBOUNCE_CYCLES` produces no change.
- **Press detect:** `press` = `db` rising edge, registered; one cycle wide. Releases produce no action.
- **Mode FSM:** three states, MODE_SHIFT=00, MODE_COUNT=01, MODE_JOHNSON=10.
  - On a `btn_next` press: 00→01→10→00.
  - Code 11 is never emitted. If 11 is ever present, the next press goes to 00.
  - On every mode transition, `pattern_rst`=1 for exactly the cycle in which the new `mode` is first visible.
- **Run/pause:** a `btn_pause` press toggles `running`.
- **Prescaler:** counter over 0..`TICK_DIV`-1.
  - Counts only while `running`=1. Frozen, not cleared, while paused.
  - `step`=1 for one cycle when the counter equals `TICK_DIV`-1, then wraps to 0.
  - A mode change clears the prescaler, so the first `step` in the new mode comes a full `TICK_DIV` cycles later.
- **Simultaneous presses:** both act in the same cycle. Mode advances, `running` toggles, and `pattern_rst` pulses.
- **Mode change vs. terminal count:** if a mode change lands on the cycle where the prescaler would hit terminal count, `step` is suppressed and the prescaler clears.
- **Width rules:** counter widths are `$clog2(DEBOUNCE_CYCLES)` and `$clog2(TICK_DIV)`. No overflow is possible; counters never exceed their terminal value.

## Timing
- Raw press held steady, first sampled high at edge E:
  - `db` rises at E+1+`DEBOUNCE_CYCLES`.
  - `press` is high in the cycle after E+2+`DEBOUNCE_CYCLES`.
  - `mode`/`running` update and `pattern_rst` asserts at E+3+`DEBOUNCE_CYCLES`.
- `step` period while running: exactly `TICK_DIV` cycles, 1-cycle high.
- `reset` acts asynchronously. Reset mid-debounce discards the partial count. Reset while paused restores `running`=1.
- Holding a button produces one press only. The next press requires a debounced release first.

## Structure
- Shared package holds:
  - the `mode` code constants MODE_SHIFT, MODE_COUNT, MODE_JOHNSON, also consumed by the pattern generator;
  - the default `DEBOUNCE_CYCLES` and `TICK_DIV` values.
- One sub-module, `btn_debounce`, containing the synchroniser, stable counter and press pulse, parameterised by `DEBOUNCE_CYCLES`. Instantiated twice.
- The top level holds the mode FSM, the run flag and the prescaler.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TICK_DIV`=5.
1. Reset, then idle 20 cycles → `mode`=00, `running`=1, `step` pulses every 5 cycles, `pattern_rst` stays 0.
2. Hold `btn_next` 10 cycles, release, and repeat three times in total → `mode` goes 01, 10, 00. Each change lands 7 edges after first high sample, with one `pattern_rst` pulse per change. Next `step` is 5 cycles after each change.
3. Drive `btn_next` with a bounce pattern 1,0,1,1,0,1,1,1 (no run of 4) → `mode` unchanged, no `pattern_rst`.
4. Press `btn_pause` with the prescaler at 2 → `running`=0 and no `step`. Press again 30 cycles later → `running`=1, and the first `step` arrives 2 cycles after resume, because the prescaler resumes from 3.
5. Press `btn_next` and `btn_pause` with identical timing → `mode` advances, `running` toggles and `pattern_rst` pulses, all in the same cycle.
6. Assert `reset` 2 cycles into a held `btn_next`, release `reset`, keep holding → `mode`=00 after reset, then 01 exactly 7 edges after the post-reset first sample.
